kmp_fail_builder: RTL and testbench
===================================

KMP_FAIL_BUILDER -- requirements
Module: kmp_fail_builder

Interface
REQ-001 Parameter MAX_PAT, default 32: maximum pattern length in characters (power of two, >= 2).
REQ-002 Parameter CHAR_W, default 8: character width in bits.
REQ-003 Parameter IDX_W, default $clog2(MAX_PAT): width of one failure-table entry and of last_pat_idx.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  job request; level, held until o_valid observed.
REQ-007 pattern  input  MAX_PAT*CHAR_W  character c at bits [c*CHAR_W +: CHAR_W].
REQ-008 last_pat_idx  input  IDX_W  index of last valid character (length-1).
REQ-009 i_ready  output  1  high only in IDLE; job is accepted when i_valid && i_ready.
REQ-010 o_busy  output  1  high in CALC.
REQ-011 o_fail_func  output  MAX_PAT*IDX_W  entry q at bits [q*IDX_W +: IDX_W], registered.
REQ-012 o_valid  output  1  high in DONE; table is stable and complete.

Function
REQ-013 FSM states IDLE, CALC, DONE; IDLE->CALC on acceptance; CALC->DONE after the final entry is written; DONE->IDLE on the first cycle that i_valid is low.
REQ-014 On acceptance: latch pattern and last_pat_idx internally, so input changes during CALC are ignored; clear the entire o_fail_func to 0.
REQ-015 Compute the full KMP prefix function: f[q] = length of the longest proper prefix of p[0..q] that is also a suffix of it.
REQ-016 Internal q and k registers are IDX_W+1 bits wide, so q = MAX_PAT is representable without wrap.
REQ-017 CALC cycle 1 (init): f[0]=0, q=1, k=0.
REQ-018 Each later CALC cycle performs exactly one step:
- p[k]==p[q]: f[q]=k+1, k=k+1, q=q+1.
- mismatch with k>0: fallback, k=f[k-1], no write, q unchanged.
- mismatch with k==0: f[q]=0, q=q+1.
REQ-019 CALC exits to DONE in the same cycle that q increments past last_pat_idx; o_valid rises the following cycle.
REQ-020 Edge case last_pat_idx==0: CALC lasts only the init cycle, and the table is all zero.
REQ-021 CALC length = 1 + last_pat_idx + number of fallback steps, bounded by 2*(last_pat_idx+1) cycles.
REQ-022 Entries above last_pat_idx remain 0.
REQ-023 o_fail_func holds its value through DONE and IDLE until the next acceptance.
REQ-024 i_valid dropping during CALC does not abort the job; DONE is then entered and exited after a single cycle (o_valid pulses one cycle).
REQ-025 i_valid held high in DONE keeps o_valid high; there is no re-acceptance until IDLE is reached.

Reset
REQ-026 reset has priority over all other inputs in every state.
REQ-027 reset forces the FSM to IDLE and clears q, k, o_fail_func, o_valid and o_busy to 0; i_ready is 1 on the cycle after reset.
REQ-028 reset asserted mid-CALC discards the job; no partial table remains visible.

Verification
REQ-029 "aaaa", last=3 -> f={0,1,2,3}; o_busy high 4 cycles; o_valid high on the 5th cycle after acceptance.
REQ-030 "abab", last=3 -> f={0,0,1,2}, 4 CALC cycles.
REQ-031 "aabaaab", last=6 -> f={0,1,0,1,2,2,3}, 9 CALC cycles (2 fallbacks).
REQ-032 last=0, any character -> f all 0, 1 CALC cycle, o_valid next cycle.
REQ-033 "aabaaab" accepted; reset asserted in CALC cycle 5 -> next cycle: IDLE, o_fail_func=0, o_valid=0, i_ready=1; a new "aaaa" job then completes correctly.
REQ-034 i_valid dropped in CALC cycle 2 of "abab" -> table still {0,0,1,2}, o_valid high exactly 1 cycle, then IDLE.

Source files
------------

// File: rtl/kmp_fail_builder.sv
// KMP failure-table builder: latches a pattern and computes its prefix function.
// Ports: clk, reset (sync, active-high), i_valid/i_ready accept handshake,
// pattern/last_pat_idx job inputs, o_busy while computing, o_valid when the
// registered o_fail_func table is complete and stable.
module kmp_fail_builder #(
  parameter int MAX_PAT = 32,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = $clog2(MAX_PAT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [MAX_PAT*CHAR_W-1:0] pattern,
  input  logic [IDX_W-1:0]          last_pat_idx,
  output logic                      i_ready,
  output logic                      o_busy,
  output logic [MAX_PAT*IDX_W-1:0]  o_fail_func,
  output logic                      o_valid
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CHAR_W-1:0] pat_q [MAX_PAT];
  logic [IDX_W-1:0]  fail_q [MAX_PAT];
  logic [IDX_W-1:0]  last_q;
  logic [IDX_W:0]    q;
  logic [IDX_W:0]    k;

  logic [IDX_W-1:0] q_i;
  logic [IDX_W-1:0] k_i;
  logic [IDX_W-1:0] km1_i;
  logic [IDX_W-1:0] one_i;
  logic             accept;
  logic             init_step;
  logic             match;
  logic             k_zero;
  logic             advance;
  logic             last_step;

  assign one_i     = {{(IDX_W-1){1'b0}}, 1'b1};
  assign q_i       = q[IDX_W-1:0];
  assign k_i       = k[IDX_W-1:0];
  assign km1_i     = k_i - one_i;
  assign accept    = (state == IDLE) && i_valid;
  // q is parked at 0 on acceptance; q==0 in CALC marks the init cycle.
  assign init_step = (q == '0);
  assign match     = (pat_q[k_i] == pat_q[q_i]);
  assign k_zero    = (k == '0);
  // q advances on init, on a match, or on a mismatch with no prefix left.
  assign advance   = init_step || match || k_zero;
  assign last_step = advance && (q == {1'b0, last_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    o_busy    = 1'b0;
    o_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_nxt = CALC;
      end
      CALC: begin
        o_busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (!i_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      k      <= '0;
      last_q <= '0;
      for (int i = 0; i < MAX_PAT; i++) begin
        fail_q[i] <= '0;
        pat_q[i]  <= '0;
      end
    end else if (accept) begin
      q      <= '0;
      k      <= '0;
      last_q <= last_pat_idx;
      for (int i = 0; i < MAX_PAT; i++) begin
        fail_q[i] <= '0;
        pat_q[i]  <= pattern[i*CHAR_W +: CHAR_W];
      end
    end else if (state == CALC) begin
      if (init_step) begin
        fail_q[0] <= '0;
        q         <= {{IDX_W{1'b0}}, 1'b1};
        k         <= '0;
      end else if (match) begin
        fail_q[q_i] <= k_i + one_i;
        k           <= k + 1'b1;
        q           <= q + 1'b1;
      end else if (!k_zero) begin
        // fall back to the next shorter border; no entry written
        k <= {1'b0, fail_q[km1_i]};
      end else begin
        fail_q[q_i] <= '0;
        q           <= q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_PAT; g++) begin : g_out
    assign o_fail_func[g*IDX_W +: IDX_W] = fail_q[g];
  end

endmodule

// File: tb/tb_kmp_fail_builder.sv
// Self-checking bench for kmp_fail_builder: directed patterns against a
// brute-force prefix-function model, with handshake, timing and reset checks.
module tb_kmp_fail_builder;

  localparam int MP = 32;
  localparam int CW = 8;
  localparam int IW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic [MP*CW-1:0] pattern;
  logic [IW-1:0]    last_pat_idx;
  logic             i_ready;
  logic             o_busy;
  logic [MP*IW-1:0] o_fail_func;
  logic             o_valid;

  int checks   = 0;
  int failures = 0;

  logic [MP*IW-1:0] exp_tbl = '0;
  bit               chk_en  = 1'b0;

  kmp_fail_builder #(.MAX_PAT(MP), .CHAR_W(CW), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .pattern      (pattern),
    .last_pat_idx (last_pat_idx),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_fail_func  (o_fail_func),
    .o_valid      (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check_tbl(string name, logic [MP*IW-1:0] act,
                           logic [MP*IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Prefix function straight from its definition: longest proper prefix
  // of p[0..q] that is also a suffix of it, found by brute force.
  function automatic logic [MP*IW-1:0] model(logic [MP*CW-1:0] p, int last);
    logic [MP*IW-1:0] r;
    bit ok;
    r = '0;
    for (int q = 0; q <= last; q++) begin
      for (int len = q; len >= 1; len--) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++)
          if (p[i*CW +: CW] != p[(q-len+1+i)*CW +: CW]) ok = 1'b0;
        if (ok) begin
          r[q*IW +: IW] = IW'(len);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MP*CW-1:0] mkpat(string s);
    logic [MP*CW-1:0] p;
    for (int c = 0; c < MP; c++)
      p[c*CW +: CW] = (c < s.len()) ? s[c] : CW'($urandom_range(97, 99));
    return p;
  endfunction

  function automatic logic [MP*IW-1:0] pack(int n, int a[8]);
    logic [MP*IW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*IW +: IW] = IW'(a[i]);
    return r;
  endfunction

  // Whenever a finished table is on the outputs it must match the model.
  always @(negedge clk) begin
    if (!reset && (o_valid || chk_en))
      check_tbl("table", o_fail_func, exp_tbl);
  end

  task automatic start_job(string s, output logic [MP*CW-1:0] p);
    p = mkpat(s);
    @(negedge clk);
    check_int({s, " ready"}, int'(i_ready), 1);
    chk_en       = 1'b0;
    pattern      = p;
    last_pat_idx = IW'(s.len() - 1);
    exp_tbl      = model(p, s.len() - 1);
    i_valid      = 1'b1;
    @(posedge clk);
    #1;
    pattern      = ~p;
    last_pat_idx = ~last_pat_idx;
  endtask

  task automatic run_job(string s, int exp_calc, bit drop2);
    logic [MP*CW-1:0] p;
    int busy;
    busy = 0;
    start_job(s, p);
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (!o_busy) break;
      busy++;
      if (drop2 && busy == 2) i_valid = 1'b0;
    end
    if (exp_calc >= 0)
      check_int({s, " calc_cycles"}, busy, exp_calc);
    checks++;
    if (busy < s.len() || busy > 2 * s.len()) begin
      failures++;
      $display("FAIL %s calc_bound actual=%0d required=%0d..%0d",
               s, busy, s.len(), 2 * s.len());
    end
    check_int({s, " valid_rise"}, int'(o_valid), 1);
    chk_en = 1'b1;
    if (drop2) begin
      @(negedge clk);
      check_int({s, " valid_pulse"}, int'(o_valid), 0);
      check_int({s, " idle_ready"}, int'(i_ready), 1);
    end else begin
      @(negedge clk);
      check_int({s, " valid_hold"}, int'(o_valid), 1);
      check_int({s, " no_reaccept"}, int'(i_ready), 0);
      i_valid = 1'b0;
      @(negedge clk);
      check_int({s, " valid_fall"}, int'(o_valid), 0);
      check_int({s, " idle_ready"}, int'(i_ready), 1);
    end
  endtask

  task automatic run_reset_mid(string s, int at_cycle);
    logic [MP*CW-1:0] p;
    int busy;
    busy = 0;
    start_job(s, p);
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (!o_busy) break;
      busy++;
      if (busy == at_cycle) break;
    end
    check_int("rst_mid reached", busy, at_cycle);
    reset   = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    check_int("rst_mid ready", int'(i_ready), 1);
    check_int("rst_mid valid", int'(o_valid), 0);
    check_int("rst_mid busy", int'(o_busy), 0);
    check_tbl("rst_mid table", o_fail_func, '0);
    reset   = 1'b0;
    exp_tbl = '0;
  endtask

  initial begin
    string sa;
    string sb;
    reset        = 1'b1;
    i_valid      = 1'b0;
    pattern      = '0;
    last_pat_idx = '0;
    repeat (3) @(negedge clk);
    check_int("reset ready", int'(i_ready), 1);
    check_int("reset busy", int'(o_busy), 0);
    check_int("reset valid", int'(o_valid), 0);
    check_tbl("reset table", o_fail_func, '0);
    reset = 1'b0;

    check_tbl("model aaaa", model(mkpat("aaaa"), 3),
              pack(4, '{0, 1, 2, 3, 0, 0, 0, 0}));
    check_tbl("model abab", model(mkpat("abab"), 3),
              pack(4, '{0, 0, 1, 2, 0, 0, 0, 0}));
    check_tbl("model aabaaab", model(mkpat("aabaaab"), 6),
              pack(7, '{0, 1, 0, 1, 2, 2, 3, 0}));
    check_tbl("model x", model(mkpat("x"), 0), '0);

    run_job("aaaa", 4, 1'b0);
    run_job("abab", 4, 1'b0);
    run_job("aabaaab", 9, 1'b0);
    run_job("x", 1, 1'b0);
    run_job("abab", 4, 1'b1);
    run_reset_mid("aabaaab", 5);
    run_job("aaaa", 4, 1'b0);
    run_job("abcabcabx", -1, 1'b0);
    run_job("abacabab", -1, 1'b0);

    sa = "";
    for (int i = 0; i < MP; i++) sa = {sa, "a"};
    run_job(sa, MP, 1'b0);
    sb = "";
    for (int i = 0; i < MP - 1; i++) sb = {sb, "a"};
    sb = {sb, "b"};
    run_job(sb, -1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
